bp_cce_fetch_ctrl: RTL and testbench
====================================

Name: bp_cce_fetch_ctrl

Overview:
- Fetch/PC sequencer for the CCE microcode engine.
- Owns the fetch PC and drives the synchronous instruction RAM address.
- Applies static branch prediction to each fetched instruction, then hands the PC, predicted-taken bit and target to the execute stage, where the branch unit resolves them.
- On a mispredict from the branch unit, redirects fetch to the resolved PC and squashes the wrong-path instruction.

Parameters:
- cce_pc_width_p, "inv", width of microcode PC; instruction RAM depth is 2^cce_pc_width_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-high
- start_i  in  1  pulse in IDLE; begins fetch at boot_pc_i
- boot_pc_i  in  cce_pc_width_p  first PC fetched after start
- ram_v_o  out  1  instruction RAM read enable
- ram_addr_o  out  cce_pc_width_p  instruction RAM read address (combinational next PC)
- fetch_branch_i  in  1  decoded instruction currently at RAM output is a branch
- fetch_pred_taken_i  in  1  predict bit of that instruction
- fetch_target_i  in  cce_pc_width_p  branch target of that instruction
- stall_i  in  1  execute stage cannot accept a new instruction this cycle
- mispredict_i  in  1  branch unit reports mispredict for the execute-stage instruction
- resolved_pc_i  in  cce_pc_width_p  branch unit's correct next PC
- ex_v_o  out  1  execute stage holds a valid instruction
- ex_pc_o  out  cce_pc_width_p  PC of execute-stage instruction (to branch unit)
- ex_pred_taken_o  out  1  prediction made for execute-stage instruction
- ex_target_o  out  cce_pc_width_p  branch target of execute-stage instruction
- fetch_pc_o  out  cce_pc_width_p  PC of instruction at RAM output

Behaviour:
- States: e_fetch_reset, e_fetch_idle, e_fetch_run.
- Reset:
  - State goes to e_fetch_reset; all registered outputs are 0; ram_v_o = 0.
  - Next cycle moves to e_fetch_idle unconditionally.
  - Reset asserted in any state overrides all other inputs that cycle.
- e_fetch_idle:
  - ram_v_o = 0; ex_v_o = 0.
  - On start_i: ram_v_o = 1, ram_addr_o = boot_pc_i, fetch_pc_r <= boot_pc_i, go to e_fetch_run.
  - start_i is ignored outside idle.
- e_fetch_run: ram_v_o = 1 every cycle. RAM data lags its address by one cycle, so the data at the RAM output always belongs to fetch_pc_r. Each cycle, exactly one of the following applies, in priority order:
  1. Mispredict (mispredict_i & ex_v_o & ~stall_i):
     - ram_addr_o = resolved_pc_i; fetch_pc_r <= resolved_pc_i.
     - ex_v_r <= 0; the instruction at the RAM output is wrong-path.
     - Penalty is one bubble.
  2. Stall (stall_i):
     - ram_addr_o = fetch_pc_r (re-read); all registers hold.
     - mispredict_i is ignored while stalled.
  3. Advance:
     - pred = fetch_branch_i & fetch_pred_taken_i.
     - next = pred ? fetch_target_i : fetch_pc_r + 1.
     - ram_addr_o = next; fetch_pc_r <= next.
     - ex_v_r <= 1, ex_pc_r <= fetch_pc_r, ex_pred_r <= pred, ex_target_r <= fetch_target_i.
- The first cycle in run always takes the advance or stall path, because ex_v_r = 0.
- Arithmetic: PC+1 is modulo 2^cce_pc_width_p; all-ones wraps to 0.
- A mispredict whose resolved PC equals the wrong-path PC is still treated as a redirect (squash + re-fetch).
- ex_pred_taken_o is 0 for non-branches.

Optional Feature:
- Macro: BP_CCE_FETCH_PREDICT_EN.
- Defined: prediction as above.
- Undefined:
  - pred is forced to 0, so every branch is predicted not-taken.
  - fetch_pred_taken_i is unused.
  - ex_pred_taken_o is tied to 0.
  - Taken branches resolve through the mispredict path.

Decomposition:
- bp_cce_pkg gets:
  - the typedef enum bp_cce_fetch_state_e {e_fetch_reset, e_fetch_idle, e_fetch_run}, 2-bit;
  - the constant bp_cce_fetch_bubble_gp = 1.
- One natural sub-module: bp_cce_fetch_next_pc, the combinational priority mux for redirect/hold/predict/increment. The FSM and pipeline registers stay in the top.

Test Plan (all with cce_pc_width_p = 8):
- Boot: reset 2 cycles, start_i with boot_pc_i = 0x10 → ram_addr_o = 0x10 in the start cycle; next cycle fetch_pc_o = 0x10, ram_addr_o = 0x11; following cycle ex_v_o = 1, ex_pc_o = 0x10.
- Predicted taken: fetch_pc 0x12 is a branch with predict = 1, target 0x40 → ram_addr_o = 0x40; next cycle ex_pc_o = 0x12, ex_pred_taken_o = 1, ex_target_o = 0x40. With BP_CCE_FETCH_PREDICT_EN undefined → ram_addr_o = 0x13, ex_pred_taken_o = 0.
- Mispredict: ex_pc 0x12 with mispredict_i = 1, resolved_pc_i = 0x13 → ram_addr_o = 0x13 same cycle; next cycle ex_v_o = 0, fetch_pc_o = 0x13; the cycle after, ex_pc_o = 0x13.
- Stall: stall_i held 3 cycles at fetch_pc 0x20 with mispredict_i = 1 → ram_addr_o = 0x20 throughout, ex_* unchanged, no redirect; release → ram_addr_o = 0x21.
- Wrap: fetch_pc 0xFF, non-branch → ram_addr_o = 0x00.
- Reset mid-run: assert reset_i during a mispredict cycle → next cycle ex_v_o = 0, ram_v_o = 0, state reset, then idle; start_i is ignored until idle is reached.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// -----------------------------------------------------------------------------
// bp_cce_pkg
//   Shared types and constants for the CCE microcode fetch controller.
//   - bp_cce_fetch_state_e : fetch sequencer states (2-bit encoding)
//   - bp_cce_fetch_bubble_gp : bubbles inserted by a branch mispredict
// -----------------------------------------------------------------------------
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_fetch_reset = 2'd0,
    e_fetch_idle  = 2'd1,
    e_fetch_run   = 2'd2
  } bp_cce_fetch_state_e;

  // A redirect squashes exactly the one wrong-path instruction sitting at the
  // RAM output, so a mispredict costs a single bubble in execute.
  localparam int bp_cce_fetch_bubble_gp = 1;

endpackage : bp_cce_pkg

// File: rtl/bp_cce_fetch_next_pc.sv
// -----------------------------------------------------------------------------
// bp_cce_fetch_next_pc
//   Combinational next-PC selection for the CCE fetch sequencer.
//   Priority: redirect > hold > predicted-taken target > PC + 1 (modulo 2^W).
//
// Ports:
//   redirect_i     - branch unit redirect (mispredict) this cycle
//   redirect_pc_i  - resolved PC to redirect to
//   hold_i         - stall: re-read the current PC
//   cur_pc_i       - PC of the instruction at the RAM output
//   pred_taken_i   - static prediction says taken
//   target_i       - branch target of the current instruction
//   next_pc_o      - PC to present to the instruction RAM
// -----------------------------------------------------------------------------
module bp_cce_fetch_next_pc #(
  parameter int cce_pc_width_p = 8
) (
  input  logic                      redirect_i,
  input  logic [cce_pc_width_p-1:0] redirect_pc_i,
  input  logic                      hold_i,
  input  logic [cce_pc_width_p-1:0] cur_pc_i,
  input  logic                      pred_taken_i,
  input  logic [cce_pc_width_p-1:0] target_i,
  output logic [cce_pc_width_p-1:0] next_pc_o
);

  always_comb begin
    if (redirect_i) begin
      next_pc_o = redirect_pc_i;
    end else if (hold_i) begin
      next_pc_o = cur_pc_i;
    end else if (pred_taken_i) begin
      next_pc_o = target_i;
    end else begin
      // Width-limited add: the all-ones PC wraps to zero.
      next_pc_o = cur_pc_i + 1'b1;
    end
  end

endmodule : bp_cce_fetch_next_pc

// File: rtl/bp_cce_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// bp_cce_fetch_ctrl
//   Fetch/PC sequencer for the CCE microcode engine. Owns the fetch PC, drives
//   the synchronous instruction RAM, applies static branch prediction and hands
//   PC / prediction / target to the execute stage. A mispredict from the branch
//   unit redirects fetch and squashes the wrong-path instruction.
//
// Configuration:
//   BP_CCE_FETCH_PREDICT_EN - when defined, branches with their predict bit set
//     are fetched down the taken path. When undefined every branch is predicted
//     not-taken, fetch_pred_taken_i is unused and ex_pred_taken_o is tied to 0.
//
// Ports:
//   clk_i, reset_i         - clock; synchronous active-high reset
//   start_i, boot_pc_i     - start pulse (idle only) and first PC to fetch
//   ram_v_o, ram_addr_o    - instruction RAM read enable / next address
//   fetch_branch_i, fetch_pred_taken_i, fetch_target_i
//                          - decode of the instruction at the RAM output
//   stall_i                - execute cannot accept an instruction
//   mispredict_i, resolved_pc_i
//                          - branch unit redirect for the execute instruction
//   ex_v_o, ex_pc_o, ex_pred_taken_o, ex_target_o
//                          - execute-stage instruction state
//   fetch_pc_o             - PC of the instruction at the RAM output
// -----------------------------------------------------------------------------
module bp_cce_fetch_ctrl
  import bp_cce_pkg::*;
#(
  parameter int cce_pc_width_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [cce_pc_width_p-1:0] boot_pc_i,
  output logic                      ram_v_o,
  output logic [cce_pc_width_p-1:0] ram_addr_o,
  input  logic                      fetch_branch_i,
  input  logic                      fetch_pred_taken_i,
  input  logic [cce_pc_width_p-1:0] fetch_target_i,
  input  logic                      stall_i,
  input  logic                      mispredict_i,
  input  logic [cce_pc_width_p-1:0] resolved_pc_i,
  output logic                      ex_v_o,
  output logic [cce_pc_width_p-1:0] ex_pc_o,
  output logic                      ex_pred_taken_o,
  output logic [cce_pc_width_p-1:0] ex_target_o,
  output logic [cce_pc_width_p-1:0] fetch_pc_o
);

  bp_cce_fetch_state_e       state_q, state_d;
  logic [cce_pc_width_p-1:0] fetch_pc_q, fetch_pc_d;
  logic                      ex_v_q, ex_v_d;
  logic [cce_pc_width_p-1:0] ex_pc_q, ex_pc_d;
  logic                      ex_pred_q, ex_pred_d;
  logic [cce_pc_width_p-1:0] ex_target_q, ex_target_d;

  logic                      pred;
  logic                      redirect;
  logic                      ram_v;
  logic [cce_pc_width_p-1:0] next_pc;

`ifdef BP_CCE_FETCH_PREDICT_EN
  assign pred            = fetch_branch_i & fetch_pred_taken_i;
  assign ex_pred_taken_o = ex_pred_q;
`else
  // Static not-taken: taken branches come back through the mispredict path.
  logic unused_pred;
  assign pred            = 1'b0;
  assign ex_pred_taken_o = 1'b0;
  assign unused_pred     = fetch_pred_taken_i ^ ex_pred_q ^ fetch_branch_i;
`endif

  // Mispredicts only count for a valid execute instruction that is actually
  // leaving execute; while stalled the branch unit's verdict is not final.
  assign redirect = mispredict_i & ex_v_q & ~stall_i;

  bp_cce_fetch_next_pc #(
    .cce_pc_width_p(cce_pc_width_p)
  ) next_pc_mux (
    .redirect_i   (redirect),
    .redirect_pc_i(resolved_pc_i),
    .hold_i       (stall_i),
    .cur_pc_i     (fetch_pc_q),
    .pred_taken_i (pred),
    .target_i     (fetch_target_i),
    .next_pc_o    (next_pc)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    ex_v_d      = ex_v_q;
    ex_pc_d     = ex_pc_q;
    ex_pred_d   = ex_pred_q;
    ex_target_d = ex_target_q;
    ram_v       = 1'b0;
    ram_addr_o  = fetch_pc_q;

    unique case (state_q)
      e_fetch_reset: begin
        state_d = e_fetch_idle;
      end

      e_fetch_idle: begin
        ram_addr_o = boot_pc_i;
        if (start_i) begin
          ram_v      = 1'b1;
          fetch_pc_d = boot_pc_i;
          state_d    = e_fetch_run;
        end
      end

      e_fetch_run: begin
        // RAM data lags its address by a cycle, so the word at the output
        // always belongs to fetch_pc_q; next_pc becomes its successor.
        ram_v      = 1'b1;
        ram_addr_o = next_pc;
        fetch_pc_d = next_pc;
        if (redirect) begin
          ex_v_d = 1'b0;
        end else if (!stall_i) begin
          ex_v_d      = 1'b1;
          ex_pc_d     = fetch_pc_q;
          ex_pred_d   = pred;
          ex_target_d = fetch_target_i;
        end
      end

      default: begin
        state_d = e_fetch_reset;
      end
    endcase
  end

  // Reset overrides the RAM request in the cycle it is asserted as well.
  assign ram_v_o = ram_v & ~reset_i;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_fetch_reset;
      fetch_pc_q  <= '0;
      ex_v_q      <= 1'b0;
      ex_pc_q     <= '0;
      ex_pred_q   <= 1'b0;
      ex_target_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      ex_v_q      <= ex_v_d;
      ex_pc_q     <= ex_pc_d;
      ex_pred_q   <= ex_pred_d;
      ex_target_q <= ex_target_d;
    end
  end

  assign ex_v_o      = ex_v_q;
  assign ex_pc_o     = ex_pc_q;
  assign ex_target_o = ex_target_q;
  assign fetch_pc_o  = fetch_pc_q;

endmodule : bp_cce_fetch_ctrl

// File: tb/tb_bp_cce_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bp_cce_fetch_ctrl
//   Self-checking bench for bp_cce_fetch_ctrl (cce_pc_width_p = 8). A directed
//   walk through boot, prediction, mispredict, stall, wrap and mid-run reset is
//   followed by randomized traffic; every cycle is compared against a
//   behavioural model of the fetch sequencer. Honours BP_CCE_FETCH_PREDICT_EN.
// -----------------------------------------------------------------------------
module tb_bp_cce_fetch_ctrl;

`ifdef BP_CCE_FETCH_PREDICT_EN
  localparam bit pred_en = 1'b1;
`else
  localparam bit pred_en = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i, start_i, fetch_branch_i, fetch_pred_taken_i;
  logic       stall_i, mispredict_i;
  logic [7:0] boot_pc_i, fetch_target_i, resolved_pc_i;
  logic       ram_v_o, ex_v_o, ex_pred_taken_o;
  logic [7:0] ram_addr_o, ex_pc_o, ex_target_o, fetch_pc_o;

  bp_cce_fetch_ctrl #(.cce_pc_width_p(8)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .boot_pc_i         (boot_pc_i),
    .ram_v_o           (ram_v_o),
    .ram_addr_o        (ram_addr_o),
    .fetch_branch_i    (fetch_branch_i),
    .fetch_pred_taken_i(fetch_pred_taken_i),
    .fetch_target_i    (fetch_target_i),
    .stall_i           (stall_i),
    .mispredict_i      (mispredict_i),
    .resolved_pc_i     (resolved_pc_i),
    .ex_v_o            (ex_v_o),
    .ex_pc_o           (ex_pc_o),
    .ex_pred_taken_o   (ex_pred_taken_o),
    .ex_target_o       (ex_target_o),
    .fetch_pc_o        (fetch_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the sequencer is "waking" for one cycle after reset,
  // then "idle" until started, then "running".
  typedef enum int {m_waking, m_idle, m_running} model_mode_e;
  model_mode_e m_mode  = m_waking;
  int          m_fetch = 0;
  bit          m_ex_v  = 0;
  int          m_ex_pc = 0;
  bit          m_ex_pred = 0;
  int          m_ex_tgt  = 0;

  // Called half a cycle before a rising edge with inputs already applied.
  task automatic step();
    bit exp_v;
    int exp_addr;
    bit taken;
    #1;
    check("ex_v",      ex_v_o,          m_ex_v);
    check("ex_pc",     ex_pc_o,         m_ex_pc);
    check("ex_pred",   ex_pred_taken_o, pred_en ? m_ex_pred : 1'b0);
    check("ex_target", ex_target_o,     m_ex_tgt);
    check("fetch_pc",  fetch_pc_o,      m_fetch);

    exp_v    = 0;
    exp_addr = 0;
    if (reset_i) begin
      m_mode = m_waking; m_fetch = 0; m_ex_v = 0;
      m_ex_pc = 0; m_ex_pred = 0; m_ex_tgt = 0;
    end else if (m_mode == m_waking) begin
      m_mode = m_idle;
    end else if (m_mode == m_idle) begin
      if (start_i) begin
        exp_v = 1; exp_addr = boot_pc_i; m_fetch = boot_pc_i; m_mode = m_running;
      end
    end else begin
      exp_v = 1;
      if (mispredict_i && m_ex_v && !stall_i) begin
        exp_addr = resolved_pc_i; m_fetch = resolved_pc_i; m_ex_v = 0;
      end else if (stall_i) begin
        exp_addr = m_fetch;
      end else begin
        taken     = pred_en && fetch_branch_i && fetch_pred_taken_i;
        exp_addr  = taken ? int'(fetch_target_i) : (m_fetch + 1) % 256;
        m_ex_v    = 1;
        m_ex_pc   = m_fetch;
        m_ex_pred = taken;
        m_ex_tgt  = fetch_target_i;
        m_fetch   = exp_addr;
      end
    end
    check("ram_v", ram_v_o, exp_v);
    if (exp_v) check("ram_addr", ram_addr_o, exp_addr);
    @(negedge clk_i);
  endtask

  task automatic drive(input bit rst, input bit st, input logic [7:0] boot,
                       input bit br, input bit pt, input logic [7:0] tgt,
                       input bit stl, input bit mp, input logic [7:0] res);
    reset_i = rst; start_i = st; boot_pc_i = boot;
    fetch_branch_i = br; fetch_pred_taken_i = pt; fetch_target_i = tgt;
    stall_i = stl; mispredict_i = mp; resolved_pc_i = res;
    step();
  endtask

  task automatic nop();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  initial begin
    reset_i = 1; start_i = 0; boot_pc_i = 0; fetch_branch_i = 0;
    fetch_pred_taken_i = 0; fetch_target_i = 0; stall_i = 0;
    mispredict_i = 0; resolved_pc_i = 0;
    @(negedge clk_i);

    // Boot: two reset cycles, one wake-up cycle, then start at 0x10.
    drive(1, 1, 8'h33, 0, 0, 8'h00, 0, 0, 8'h00);
    drive(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
    drive(0, 1, 8'h77, 0, 0, 8'h00, 0, 0, 8'h00);  // start ignored while waking
    drive(0, 1, 8'h10, 0, 0, 8'h00, 0, 0, 8'h00);  // addr 0x10
    drive(0, 1, 8'h55, 0, 0, 8'h00, 0, 0, 8'h00);  // fetch 0x10, addr 0x11
    check("boot_ex_pc", ex_pc_o, 8'h10);           // execute now holds 0x10
    check("boot_ex_v",  ex_v_o,  1'b1);

    // Predicted-taken branch at 0x12 with target 0x40.
    nop();                                          // 0x11 -> 0x12
    drive(0, 0, 8'h00, 1, 1, 8'h40, 0, 0, 8'h00);
    check("br_ex_pc", ex_pc_o, 8'h12);
    check("br_ex_target", ex_target_o, 8'h40);
    check("br_fetch", fetch_pc_o, pred_en ? 8'h40 : 8'h13);

    // Mispredict for 0x12 resolving to 0x13, then one bubble.
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h13);
    check("mp_bubble", ex_v_o, 1'b0);
    nop();
    check("mp_ex_pc", ex_pc_o, 8'h13);

    // Stall at 0x20 with mispredict asserted: no redirect.
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h1F);
    nop();                                          // fetch 0x20, ex valid
    repeat (3) drive(0, 0, 8'h00, 1, 1, 8'h99, 1, 1, 8'h55);
    nop();                                          // release -> 0x21

    // Wrap: redirect to 0xFF, then a non-branch advances to 0x00.
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'hFF);
    nop();
    check("wrap_fetch", fetch_pc_o, 8'h00);

    // Reset during a mispredict cycle; start ignored until idle.
    drive(1, 1, 8'h66, 0, 0, 8'h00, 0, 1, 8'hAA);
    drive(0, 1, 8'h66, 0, 0, 8'h00, 0, 0, 8'h00);  // waking: start ignored
    drive(0, 1, 8'h80, 0, 0, 8'h00, 0, 0, 8'h00);  // idle: start accepted
    nop();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] res;
      res = ($urandom_range(0, 3) == 0) ? fetch_pc_o : 8'($urandom);
      drive(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 3) == 0),
            8'($urandom),
            ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1) == 1,
            8'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bp_cce_fetch_ctrl
